// File: rtl/s2p_deser_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | s2p_deser_if : serial-in / parallel-out bus bundle for s2p_deser      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface s2p_deser_if #(
  parameter int WIDTH = 8
);
  logic             serin;
  logic             sin_valid;
  logic             frame_clr;
  logic [WIDTH-1:0] parout;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;

  modport master (
    output serin, sin_valid, frame_clr, out_ready,
    input  parout, out_valid, busy, overrun
  );

  modport slave (
    input  serin, sin_valid, frame_clr, out_ready,
    output parout, out_valid, busy, overrun
  );
endinterface
`default_nettype wire

// File: rtl/s2p_deser.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | s2p_deser : MSB-first serial-to-parallel deserializer, valid/ready    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module s2p_deser #(
  parameter int WIDTH = 8
) (
  input  wire         clk,
  input  wire         rst_n,
  s2p_deser_if.slave  bus
);
  localparam int           CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  logic [WIDTH-2:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_parout;
  logic             r_out_valid;
  logic             r_overrun;

  logic [WIDTH-1:0] w_word;
  logic             w_take;
  logic             w_complete;
  logic             w_accept;
  logic             w_load;

  assign w_word     = {r_shift, bus.serin};
  assign w_take     = bus.sin_valid & ~bus.frame_clr;
  assign w_complete = w_take & (r_cnt == C_LAST);
  assign w_accept   = r_out_valid & bus.out_ready;
  // Output slot is free if empty or being drained on this same edge.
  assign w_load     = w_complete & (~r_out_valid | bus.out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_parout    <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (bus.frame_clr) begin
        r_shift   <= '0;
        r_cnt     <= '0;
        r_overrun <= 1'b0;
      end else if (bus.sin_valid) begin
        r_shift <= w_word[WIDTH-2:0];
        r_cnt   <= (r_cnt == C_LAST) ? '0 : r_cnt + CW'(1);
        if (w_complete && !w_load)
          r_overrun <= 1'b1;
      end

      if (w_load) begin
        r_parout    <= w_word;
        r_out_valid <= 1'b1;
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.parout    = r_parout;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = (r_cnt != '0);
  assign bus.overrun   = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_s2p_deser.sv
`default_nettype none
// Self-checking bench for s2p_deser: scoreboard queue of expected words.
module tb_s2p_deser;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;

  s2p_deser_if #(.WIDTH(8)) bus ();

  s2p_deser #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    bus.serin     = b;
    bus.sin_valid = 1'b1;
    tick();
    bus.sin_valid = 1'b0;
  endtask

  task automatic drive_bits(input logic [7:0] w, input int n);
    for (int i = 7; i > 7 - n; i--) drive_bit(w[i]);
  endtask

  task automatic check_word(input string name);
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL %s out_valid: got %b expected 1", name, bus.out_valid);
    end
    total++;
    if (bus.parout !== exp_w) begin
      bad++; $display("FAIL %s parout: got %h expected %h", name, bus.parout, exp_w);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.serin = 1'b0; bus.sin_valid = 1'b0; bus.frame_clr = 1'b0; bus.out_ready = 1'b0;
    #12;
    total++;
    if ({bus.parout, bus.out_valid, bus.busy, bus.overrun} !== 11'd0) begin
      bad++; $display("FAIL reset_init: got %h/%b/%b/%b expected 0", bus.parout, bus.out_valid, bus.busy, bus.overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    drive_bit(1'b1);
    total++;
    if (bus.busy !== 1'b1) begin
      bad++; $display("FAIL basic_busy1: got %b expected 1", bus.busy);
    end
    exp_q.push_back(8'hA5);
    drive_bits(8'h4A, 7);  // remaining bits 0,1,0,0,1,0,1 of 0xA5
    check_word("basic");
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL basic_busy0: got %b expected 0", bus.busy);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL basic_drop: got %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_gapped();
    logic [7:0] w;
    w = 8'hC3;
    bus.out_ready = 1'b1;
    exp_q.push_back(w);
    for (int i = 7; i >= 0; i--) begin
      drive_bit(w[i]);
      if (i != 0) begin
        bus.serin = ~w[i];
        tick();
        total++;
        if (bus.busy !== 1'b1) begin
          bad++; $display("FAIL gap_busy bit%0d: got %b expected 1", i, bus.busy);
        end
      end
    end
    check_word("gapped");
    tick();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    exp_q.push_back(8'h12);
    drive_bits(8'h12, 8);
    check_word("b2b_first");
    drive_bits(8'h34, 7);
    bus.out_ready = 1'b1;
    exp_q.push_back(8'h34);
    drive_bit(1'b0);
    check_word("b2b_second");
    total++;
    if (bus.overrun !== 1'b0) begin
      bad++; $display("FAIL b2b_overrun: got %b expected 0", bus.overrun);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_drain: got %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_overrun();
    bus.out_ready = 1'b0;
    exp_q.push_back(8'h55);
    drive_bits(8'h55, 8);
    check_word("ovr_first");
    drive_bits(8'hAA, 8);
    total++;
    if (bus.parout !== 8'h55 || bus.overrun !== 1'b1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL ovr_drop: got parout=%h ovr=%b busy=%b expected 55/1/0", bus.parout, bus.overrun, bus.busy);
    end
    bus.frame_clr = 1'b1;
    tick();
    bus.frame_clr = 1'b0;
    total++;
    if (bus.overrun !== 1'b0 || bus.out_valid !== 1'b1 || bus.parout !== 8'h55) begin
      bad++; $display("FAIL ovr_clr: got ovr=%b ov=%b parout=%h expected 0/1/55", bus.overrun, bus.out_valid, bus.parout);
    end
    bus.out_ready = 1'b1;
    tick();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL ovr_drain: got %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_realign();
    bus.out_ready = 1'b1;
    drive_bits(8'hE0, 3);
    total++;
    if (bus.busy !== 1'b1) begin
      bad++; $display("FAIL realign_partial: got %b expected 1", bus.busy);
    end
    bus.frame_clr = 1'b1;
    bus.sin_valid = 1'b1;
    bus.serin = 1'b1;
    tick();
    bus.frame_clr = 1'b0;
    bus.sin_valid = 1'b0;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL realign_busy: got %b expected 0", bus.busy);
    end
    exp_q.push_back(8'h81);
    drive_bits(8'h81, 8);
    check_word("realign");
    tick();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    exp_q.push_back(8'h55);
    drive_bits(8'h55, 8);
    check_word("rstmid_pending");
    drive_bits(8'hFF, 3);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.parout, bus.out_valid, bus.busy, bus.overrun} !== 11'd0) begin
      bad++; $display("FAIL rstmid_async: got %h/%b/%b/%b expected 0", bus.parout, bus.out_valid, bus.busy, bus.overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    exp_q.push_back(8'h3C);
    drive_bits(8'h3C, 8);
    check_word("rstmid_after");
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_gapped();
    test_back_to_back();
    test_overrun();
    test_realign();
    test_reset_mid();
    total++;
    if (exp_q.size() !== 0) begin
      bad++; $display("FAIL scoreboard_empty: got %0d expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/s2p_deser.md
Name: s2p_deser

Overview:
- Serial-to-parallel deserializer. It is the receive-side counterpart of the team's parallel-to-serial shifter.
- Accepts one serial bit per qualified clock, MSB first. After `width` bits it presents the assembled word on a registered parallel output with a valid/ready handshake.
- Sits between a serial link (or loopback from the serializer) and downstream parallel logic. Detects and flags overrun when downstream stalls.

Parameters:
- width, 8, word length in bits (>= 2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; 0 resets all state immediately.
- serin  input  1  serial data bit, MSB of each word first.
- sin_valid  input  1  serin sampled on rising clk only when 1; gaps allowed.
- frame_clr  input  1  synchronous realign; discards the partial word and restarts the bit count.
- parout  output  width  assembled word, MSB = first received bit.
- out_valid  output  1  parout holds an unconsumed word.
- out_ready  input  1  downstream accepts parout when out_valid & out_ready.
- busy  output  1  partial word in progress (bit count nonzero).
- overrun  output  1  sticky; a completed word was dropped because the output register was occupied.

Behaviour:
- Reset (rst=0, async): shift register=0, bit count=0, parout=0, out_valid=0, busy=0, overrun=0. These hold until the first rising clk after rst returns to 1.
- Shift: on a clk edge with sin_valid=1 and frame_clr=0:
  - shift register <= {shift[width-2:0], serin} (left shift, new bit enters LSB);
  - bit count increments.
- sin_valid=0: shift register and count hold.
- Bit counter range 0..width-1, register width clog2(width).
- Word completion: the edge that samples bit number `width` (count == width-1 and sin_valid=1).
  - On that edge the count wraps to 0.
  - The full word {shift[width-2:0], serin} is transferred to parout on the same edge.
  - Latency: out_valid is seen high in the cycle after the edge that samples the last bit.
- Output handshake:
  - out_valid stays 1 and parout stays stable until out_valid & out_ready on a clk edge.
  - After acceptance, out_valid falls on that edge unless a new word completes on the same edge.
- Simultaneous completion and acceptance (out_valid=1, out_ready=1, completion on the same edge):
  - new word loads into parout and out_valid stays 1;
  - no overrun.
- Overrun (completion while out_valid=1 and out_ready=0):
  - the new word is dropped and parout keeps the old word;
  - overrun is set to 1;
  - the bit count still wraps to 0, so the next word starts aligned.
- overrun is cleared only by rst or by frame_clr.
- frame_clr=1 (has priority over sin_valid):
  - clears the shift register, bit count and overrun;
  - parout and out_valid are unaffected, so a pending word still completes its handshake;
  - the bit on serin in that cycle is ignored.
- busy = (bit count != 0); combinational from the registered count.
- Continuous streaming with sin_valid held at 1 sustains one word every `width` cycles with no bubbles, provided out_ready is high.
- Reset mid-word: the partial word is lost, and the next received bit is treated as the MSB.
- The serializer's first shifted bit after load is its MSB. Loopback with matched sin_valid reproduces the loaded word.

Test Plan:
- Reset: rst=0 mid-stream with out_valid=1 -> all outputs 0 immediately, without a clk edge; after release, 8 bits of 0x3C -> parout=0x3C.
- Basic: width=8, out_ready=1, serin=1,0,1,0,0,1,0,1 with sin_valid=1 on 8 consecutive edges:
  - busy=1 after bit 1;
  - out_valid=1 and parout=0xA5 in the cycle after bit 8;
  - busy=0 then;
  - out_valid drops one cycle later.
- Gapped input: 0xC3 delivered with sin_valid toggling 1,0 every cycle -> parout=0xC3 after the 8th qualified bit, and the count holds during the gaps.
- Back-to-back and simultaneous: stream 0x12 then 0x34 continuously, with out_ready=0 until the edge that completes 0x34, then out_ready=1 on that edge -> 0x12 accepted and 0x34 loaded on that edge, out_valid stays 1, overrun=0.
- Overrun: out_ready=0, send 0x55 then 0xAA -> parout stays 0x55, overrun=1 after the 0xAA completion edge; then pulse frame_clr -> overrun=0 and out_valid still 1.
- Realign: after 3 bits of a word, pulse frame_clr, then send 0x81 -> busy=0 after the clear, parout=0x81, and the stale partial bits do not appear.
